// File: rtl/vector_lane_sequencer.sv
// Sequences a masked vector op through one shared scalar ALU, one active lane per cycle.
// Masked-off lanes are skipped entirely and keep the op1 value preloaded at capture.
module vector_lane_sequencer #(
    parameter int LANES  = 4,
    parameter int LANE_W = 32,
    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     flush,
    input  logic [LANES*LANE_W-1:0]  op1,
    input  logic [LANES*LANE_W-1:0]  op2,
    input  logic [3:0]               alu_control_in,
    input  logic [LANES-1:0]         lane_mask,
    output logic [LANE_W-1:0]        alu_op1,
    output logic [LANE_W-1:0]        alu_op2,
    output logic [3:0]               alu_ctrl,
    input  logic [LANE_W-1:0]        alu_result,
    output logic                     stall_req,
    output logic                     done,
    output logic [LANES*LANE_W-1:0]  vec_result,
    output logic [IDX_W-1:0]         lane_idx
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    typedef logic [LANES-1:0][LANE_W-1:0] vec_t;

    state_t             state_q, state_d;
    vec_t               op1_q, op1_d, op2_q, op2_d, res_q, res_d;
    logic [3:0]         ctrl_q, ctrl_d;
    logic [LANES-1:0]   mask_q, mask_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W:0]     nb;

    // Lowest set mask bit at or above 'from'; MSB of the result flags that one exists.
    function automatic logic [IDX_W:0] find_next(input logic [LANES-1:0] m, input int from);
        logic [IDX_W:0] r;
        r = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (m[i] && i >= from) r = {1'b1, IDX_W'(i)};
        end
        return r;
    endfunction

    always_comb begin
        state_d   = state_q;
        op1_d     = op1_q;
        op2_d     = op2_q;
        ctrl_d    = ctrl_q;
        mask_d    = mask_q;
        res_d     = res_q;
        idx_d     = idx_q;
        nb        = '0;
        alu_op1   = '0;
        alu_op2   = '0;
        alu_ctrl  = '0;
        stall_req = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    stall_req = 1'b1;
                    op1_d     = op1;
                    op2_d     = op2;
                    ctrl_d    = alu_control_in;
                    mask_d    = lane_mask;
                    res_d     = op1;
                    nb        = find_next(lane_mask, 0);
                    idx_d     = nb[IDX_W-1:0];
                    state_d   = nb[IDX_W] ? RUN : DONE;
                end
            end
            RUN: begin
                alu_op1  = op1_q[idx_q];
                alu_op2  = op2_q[idx_q];
                alu_ctrl = ctrl_q;
                if (!flush) begin
                    stall_req    = 1'b1;
                    res_d[idx_q] = alu_result;
                    nb           = find_next(mask_q, int'(idx_q) + 1);
                    if (nb[IDX_W]) idx_d = nb[IDX_W-1:0];
                    else           state_d = DONE;
                end
            end
            DONE: begin
                done    = !flush;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
        // Hazard unit must see no hold while reset is asserted, even if start is high.
        stall_req = stall_req & reset;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            op1_q   <= '0;
            op2_q   <= '0;
            ctrl_q  <= '0;
            mask_q  <= '0;
            res_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            ctrl_q  <= ctrl_d;
            mask_q  <= mask_d;
            res_q   <= res_d;
            idx_q   <= idx_d;
        end
    end

    assign vec_result = res_q;
    assign lane_idx   = idx_q;

endmodule

// File: doc/vector_lane_sequencer.md
VECTOR_LANE_SEQUENCER -- requirements
Module: vector_lane_sequencer

Interface
REQ-001 SHALL have parameter LANES, default 4, number of 32-bit lanes in a vector operand.
REQ-002 SHALL have parameter LANE_W, default 32, lane width in bits; the vector width is LANES*LANE_W.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  a vector op is present in EX (ex_vector_op qualified by the hazard unit).
REQ-006 SHALL have port flush  input  1  synchronous abort (driven from the EX/MEM clear).
REQ-007 SHALL have port op1  input  LANES*LANE_W  forwarded vector operand 1.
REQ-008 SHALL have port op2  input  LANES*LANE_W  forwarded vector operand 2 (or replicated immediate).
REQ-009 SHALL have port alu_control_in  input  4  ALU operation for all lanes.
REQ-010 SHALL have port lane_mask  input  LANES  per-lane enable; bit i set means lane i is computed.
REQ-011 SHALL have port alu_op1  output  LANE_W  lane operand 1 to the shared scalar ALU.
REQ-012 SHALL have port alu_op2  output  LANE_W  lane operand 2 to the shared scalar ALU.
REQ-013 SHALL have port alu_ctrl  output  4  operation to the shared ALU.
REQ-014 SHALL have port alu_result  input  LANE_W  combinational ALU result for the current lane.
REQ-015 SHALL have port stall_req  output  1  hold request to the hazard unit for IF/ID/EX.
REQ-016 SHALL have port done  output  1  one-cycle pulse; vec_result is valid.
REQ-017 SHALL have port vec_result  output  LANES*LANE_W  assembled vector result.
REQ-018 SHALL have port lane_idx  output  $clog2(LANES)  lane currently on the ALU (debug).

Function
REQ-019 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-020 In IDLE with start=1 and flush=0, SHALL capture op1, op2, alu_control_in and lane_mask into internal registers on the clock edge.
REQ-021 On that IDLE capture edge, SHALL preload vec_result with op1, so masked-off lanes hold op1.
REQ-022 On that IDLE capture edge, SHALL set lane_idx to the lowest set mask bit and go to RUN; if lane_mask=0, SHALL go directly to DONE.
REQ-023 In RUN, SHALL drive alu_op1/alu_op2 from lane lane_idx of the captured operands and drive alu_ctrl from the captured control.
REQ-024 Each RUN edge, SHALL write alu_result into lane lane_idx of vec_result.
REQ-025 Each RUN edge, SHALL advance lane_idx to the next higher set mask bit; if no higher set bit exists, SHALL go to DONE.
REQ-026 RUN SHALL take exactly popcount(mask) cycles.
REQ-027 Masked lanes SHALL consume no cycles.
REQ-028 lane_idx SHALL never wrap past LANES-1.
REQ-029 In DONE, SHALL assert done=1 for exactly one cycle, then go to IDLE.
REQ-030 vec_result SHALL hold its value until the next capture.
REQ-031 stall_req SHALL equal (state==IDLE & start & ~flush) | (state==RUN), combinationally.
REQ-032 stall_req SHALL be 0 in DONE, so the pipeline advances and latches vec_result.
REQ-033 Total latency from the start cycle to the done cycle SHALL be popcount(mask)+1 cycles; the stall lasts the same number of cycles.
REQ-034 start in RUN or DONE SHALL be ignored.
REQ-035 A new op SHALL be accepted only in IDLE; back-to-back ops are separated by the DONE cycle.
REQ-036 flush=1 in any state SHALL force IDLE on the next edge, with done=0 and stall_req=0 in that cycle.
REQ-037 flush SHALL leave vec_result unchanged.
REQ-038 flush and start asserted in the same cycle: flush SHALL win and the op SHALL not be captured.
REQ-039 In IDLE/DONE, alu_op1/alu_op2 SHALL be 0 and alu_ctrl SHALL be 0.

Reset
REQ-040 reset=0 SHALL immediately (asynchronously) force state=IDLE, lane_idx=0, vec_result=0, done=0 and all captured registers to 0.
REQ-041 stall_req SHALL be 0 while reset=0.
REQ-042 Assertion of reset mid-RUN SHALL abandon the operation with no done pulse.

Verification
REQ-043 SHALL be covered: ADD, mask=4'b1111, op1 lanes {1,2,3,4}, op2 lanes {10,20,30,40} -> stall_req high 5 cycles; done on cycle 5; vec_result lanes {11,22,33,44}.
REQ-044 SHALL be covered: mask=4'b0101, same operands -> RUN 2 cycles; lane_idx 0 then 2; vec_result lanes {11,2,33,4}; done on cycle 3.
REQ-045 SHALL be covered: mask=4'b0000 -> IDLE->DONE directly; done on cycle 1; vec_result=op1; stall_req high 1 cycle.
REQ-046 SHALL be covered: flush asserted in the second RUN cycle -> IDLE next edge, no done pulse, stall_req 0; a following start is accepted normally.
REQ-047 SHALL be covered: start and flush in the same cycle in IDLE -> no capture, stall_req=0; start held during RUN -> ignored, one done only.
REQ-048 SHALL be covered: reset driven low mid-RUN (lane_idx=2) -> all outputs 0 immediately; after release, a new op completes with correct results.
